// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined data memory: access-size encodings
// and the byte-lane helpers used for address checking and store masking.
package dmem_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SZ_B = 2'b00;
  localparam size_t SZ_H = 2'b01;
  localparam size_t SZ_W = 2'b10;
  localparam size_t SZ_D = 2'b11;

  // Lanes touched by an access, expressed for an 8-byte word; narrower words use the low bits.
  function automatic logic [7:0] byte_mask(input size_t size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  function automatic logic misaligned(input size_t size, input logic [2:0] offset);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return offset[0];
      SZ_W:    return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Final-stage load formatter: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them to the full data width.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]              word,
  input  size_t                        size,
  input  logic [$clog2(XLEN/8)-1:0]    offset,
  input  logic                         is_unsigned,
  output logic [XLEN-1:0]              rdata
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign_bit;
  int              nbits;

  // Build a low-bit keep mask and fill everything above it with the sign when required.
  always_comb begin
    shifted  = word >> {offset, 3'b000};
    nbits    = 8 << size;
    keep     = '1;
    sign_bit = 1'b0;
    rdata    = shifted;
    if (nbits < XLEN) begin
      keep     = ~({XLEN{1'b1}} << nbits);
      sign_bit = shifted[nbits-1] & ~is_unsigned;
      rdata    = (shifted & keep) | (sign_bit ? ~keep : '0);
    end
  end

endmodule

// File: rtl/data_memory_pipelined.sv
// Byte-addressable data memory with sized loads/stores, error reporting and
// a fixed-latency, fully pipelined response path.
module data_memory_pipelined
  import dmem_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int BYTES      = XLEN / 8;
  localparam int OFF_W      = $clog2(BYTES);
  localparam int IDX_FULL_W = ADDR_W - OFF_W;
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT        = READ_LATENCY;

  logic [XLEN-1:0] mem [DEPTH];

  logic                  accept;
  logic [OFF_W-1:0]      req_off;
  logic [IDX_FULL_W-1:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic                  req_err;
  logic [7:0]            mask8;
  logic [BYTES-1:0]      lane_mask;
  logic [XLEN-1:0]       wdata_shift;
  logic [XLEN-1:0]       rd_word;

  logic              st_valid_q [LAT];
  logic              st_valid_d [LAT];
  logic              st_err_q   [LAT];
  logic              st_err_d   [LAT];
  logic              st_we_q    [LAT];
  logic              st_we_d    [LAT];
  size_t             st_size_q  [LAT];
  size_t             st_size_d  [LAT];
  logic              st_uns_q   [LAT];
  logic              st_uns_d   [LAT];
  logic [OFF_W-1:0]  st_off_q   [LAT];
  logic [OFF_W-1:0]  st_off_d   [LAT];
  logic [XLEN-1:0]   st_data_q  [LAT];
  logic [XLEN-1:0]   st_data_d  [LAT];

  logic [XLEN-1:0]   aligned;

  // No backpressure: the block is ready in every cycle it is out of reset.
  assign req_ready = rst;

  always_comb begin
    accept      = req_valid & rst;
    req_off     = req_addr[OFF_W-1:0];
    word_idx    = req_addr[ADDR_W-1:OFF_W];
    mem_idx     = word_idx[IDX_W-1:0];
    req_err     = misaligned(req_size, 3'(req_off))
                | (word_idx >= IDX_FULL_W'(DEPTH))
                | ((XLEN == 32) && (req_size == SZ_D));
    mask8       = byte_mask(req_size, 3'(req_off));
    lane_mask   = mask8[BYTES-1:0];
    wdata_shift = req_wdata << {req_off, 3'b000};
    rd_word     = (!req_err && !req_we) ? mem[mem_idx] : '0;
  end

  // Array is deliberately left out of reset so committed stores survive it.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (lane_mask[b]) mem[mem_idx][b*8 +: 8] <= wdata_shift[b*8 +: 8];
      end
    end
  end

  always_comb begin
    st_valid_d[0] = accept;
    st_err_d[0]   = req_err;
    st_we_d[0]    = req_we;
    st_size_d[0]  = req_size;
    st_uns_d[0]   = req_unsigned;
    st_off_d[0]   = req_off;
    st_data_d[0]  = rd_word;
    for (int i = 1; i < LAT; i++) begin
      st_valid_d[i] = st_valid_q[i-1];
      st_err_d[i]   = st_err_q[i-1];
      st_we_d[i]    = st_we_q[i-1];
      st_size_d[i]  = st_size_q[i-1];
      st_uns_d[i]   = st_uns_q[i-1];
      st_off_d[i]   = st_off_q[i-1];
      st_data_d[i]  = st_data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        st_valid_q[i] <= 1'b0;
        st_err_q[i]   <= 1'b0;
        st_we_q[i]    <= 1'b0;
        st_size_q[i]  <= SZ_B;
        st_uns_q[i]   <= 1'b0;
        st_off_q[i]   <= '0;
        st_data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        st_valid_q[i] <= st_valid_d[i];
        st_err_q[i]   <= st_err_d[i];
        st_we_q[i]    <= st_we_d[i];
        st_size_q[i]  <= st_size_d[i];
        st_uns_q[i]   <= st_uns_d[i];
        st_off_q[i]   <= st_off_d[i];
        st_data_q[i]  <= st_data_d[i];
      end
    end
  end

  dmem_load_align #(
    .XLEN(XLEN)
  ) u_align (
    .word        (st_data_q[LAT-1]),
    .size        (st_size_q[LAT-1]),
    .offset      (st_off_q[LAT-1]),
    .is_unsigned (st_uns_q[LAT-1]),
    .rdata       (aligned)
  );

  // Response fields read as zero unless a clean load is completing.
  always_comb begin
    resp_valid = st_valid_q[LAT-1];
    resp_err   = st_valid_q[LAT-1] & st_err_q[LAT-1];
    resp_rdata = (st_valid_q[LAT-1] && !st_err_q[LAT-1] && !st_we_q[LAT-1]) ? aligned : '0;
  end

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Scoreboard bench: a byte-array reference model predicts each response at issue
// time; a negedge monitor pops and compares whenever the DUT completes a request.
module tb_data_memory_pipelined;

  localparam int XLEN   = 64;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 64;
  localparam int LAT    = 3;
  localparam int REGION = 512;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [XLEN-1:0]   req_wdata = '0;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  data_memory_pipelined #(
    .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [63:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  model [DEPTH*8];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request and predict its response from the byte-level model.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [63:0] addr, input logic [63:0] wdata);
    exp_t        e;
    int          nb;
    logic [63:0] v;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    nb     = 1 << size;
    e.cyc  = cyc + LAT;
    e.err  = ((addr % 64'(nb)) != 0) || (addr >= 64'(DEPTH * 8));
    e.data = '0;
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) model[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (64'(model[int'(addr) + i]) << (8 * i));
        if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
        e.data = v;
      end
    end
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected no pending request (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
          checkOutput("resp_err", 64'(resp_err), 64'(mon_e.err));
          checkOutput("resp_rdata", resp_rdata, mon_e.data);
        end
      end else begin
        checkOutput("idle_rdata", resp_rdata, 64'd0);
        checkOutput("idle_err", 64'(resp_err), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] addr;
    logic [1:0]  sz;
    int          r;
    int          waited;

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 64'(req_ready), 64'd0);
    checkOutput("reset_valid", 64'(resp_valid), 64'd0);
    rst = 1'b1;
    #1 checkOutput("release_ready", 64'(req_ready), 64'd1);

    for (int w = 0; w < REGION / 8; w++)
      applyStimulus(1'b1, 2'b11, 1'b0, 64'(w * 8), {$urandom, $urandom});

    // Reset with a load in flight: it must vanish without a response.
    applyStimulus(1'b0, 2'b11, 1'b0, 64'h40, 64'd0);
    #2;
    rst       = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      checkOutput("inreset_valid", 64'(resp_valid), 64'd0);
      checkOutput("inreset_ready", 64'(req_ready), 64'd0);
      checkOutput("inreset_rdata", resp_rdata, 64'd0);
    end
    rst = 1'b1;
    #1 checkOutput("rerelease_ready", 64'(req_ready), 64'd1);

    applyStimulus(1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788);
    applyStimulus(1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
    applyStimulus(1'b1, 2'b00, 1'b0, 64'h13, 64'h80);
    applyStimulus(1'b0, 2'b00, 1'b0, 64'h13, 64'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 64'h13, 64'd0);
    applyStimulus(1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
    applyStimulus(1'b1, 2'b01, 1'b0, 64'h21, 64'hBEEF);
    applyStimulus(1'b0, 2'b11, 1'b0, 64'h20, 64'd0);
    applyStimulus(1'b0, 2'b11, 1'b0, 64'h2000, 64'd0);
    idle();
    idle();

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'b11, 1'b0, 64'(64'h100 + 8 * k), {$urandom, $urandom});
      applyStimulus(1'b0, 2'b11, 1'b0, 64'(64'h100 + 8 * k), 64'd0);
    end
    idle();

    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      if (r == 0)      addr = {$urandom, $urandom};
      else if (r == 1) addr = 64'h2000 + 64'($urandom_range(0, 255));
      else             addr = 64'($urandom_range(0, REGION - 1));
      applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
                    {$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();

    waited = 0;
    while (exp_q.size() != 0 && waited < LAT + 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_pipelined.md
Name: data_memory_pipelined

Overview:
- Parametrised byte-addressable data memory for the RISC-V datapath.
- Supports sized load/store (byte/half/word/double), with sign or zero extension on loads.
- Reports misaligned and out-of-range accesses as errors.
- Read latency is configurable and fully pipelined. Requests use valid/ready; every request completes with a fixed-latency response (resp_valid).

Parameters:
- XLEN, 64, data width in bits; legal values 32 or 64.
- DEPTH, 1024, number of XLEN-wide words.
- ADDR_W, 64, byte-address width.
- READ_LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..4.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request.
- req_we, input, 1, 1 = store, 0 = load.
- req_size, input, 2, access size: 00 = byte, 01 = half, 10 = word, 11 = double.
- req_unsigned, input, 1, loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr, input, ADDR_W, byte address.
- req_wdata, input, XLEN, store data, right-justified.
- resp_valid, output, 1, completion pulse for one accepted request.
- resp_rdata, output, XLEN, load result after extension; 0 for stores and errors.
- resp_err, output, 1, the completed request was misaligned, out of range or illegal size.

Behaviour:
- Reset (rst = 0, asynchronous):
  - req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - All pipeline-stage valid bits are cleared; requests in flight are dropped and produce no response.
  - Memory contents are not cleared. Stores committed before the reset assertion persist.
- req_ready: 1 in every cycle while rst = 1. There is no backpressure; one request can be accepted per cycle.
- Accept condition: req_valid & req_ready at a rising edge.
- Address decode:
  - Word index = req_addr >> log2(XLEN/8).
  - Byte offset = req_addr[log2(XLEN/8)-1:0].
- Error conditions, evaluated at acceptance (any one sets the error):
  - Offset not a multiple of the access size.
  - Word index >= DEPTH, or any address bit above the index range is set.
  - req_size = 11 when XLEN = 32.
- Store without error:
  - Byte-lane write at the acceptance edge.
  - Lane mask: 1, 2, 4 or 8 consecutive lanes starting at the byte offset.
  - Data is the low bytes of req_wdata, shifted to the offset.
  - Unselected bytes are unchanged.
- Store with error: no array update.
- Load:
  - The word is read from the array at acceptance.
  - The array value read reflects all stores accepted in earlier cycles; a store on cycle t is visible to a load accepted on cycle t+1.
  - The offset, size and unsigned flag travel with the data down the pipeline.
  - In the final stage the selected bytes are shifted down and sign- or zero-extended to XLEN.
- Latency: an accepted request produces a response exactly READ_LATENCY cycles later.
  - Stores also produce resp_valid, with resp_rdata = 0.
  - On error: resp_err = 1, resp_rdata = 0.
- Pipeline: READ_LATENCY register stages, each holding valid, err, we, size, unsigned, offset and word data.
  - resp_* are driven from the last stage.
  - resp_rdata and resp_err are 0 whenever resp_valid = 0.
  - Back-to-back requests produce back-to-back responses, in order.
- Reset deassertion: the first request can be accepted on the first rising edge with rst = 1.

Decomposition:
- Package dmem_pkg holds:
  - Size encodings SZ_B, SZ_H, SZ_W, SZ_D.
  - Function byte_mask(size, offset).
  - Function misaligned(size, offset).
- Sub-module dmem_load_align: combinational byte-extract and sign/zero-extend, instantiated in the final stage.
- Top level holds the array, the write-mask logic and the stage registers.

Test Plan:
1. Reset: rst = 0 with a load in flight -> resp_valid stays 0 and req_ready = 0. Release rst -> req_ready = 1 on the next edge.
2. Doubleword store then load: store 0x1122334455667788 to address 0x10, then load double from 0x10 -> after READ_LATENCY cycles, resp_rdata = 0x1122334455667788, err = 0.
3. Byte lanes and extension:
   - Store byte 0x80 to address 0x13.
   - Signed byte load at 0x13 -> 0xFFFFFFFFFFFFFF80.
   - Unsigned byte load at 0x13 -> 0x80.
   - Double load at 0x10 -> 0x1122334480667788.
4. Misaligned: half store to address 0x21 -> resp_err = 1 and memory unchanged; a subsequent double load at 0x20 returns the prior value.
5. Out of range: load at address DEPTH*8 (0x2000) -> resp_err = 1, resp_rdata = 0.
6. Throughput: READ_LATENCY = 3, with stores and loads alternating every cycle for 8 cycles -> 8 consecutive resp_valid pulses starting 3 cycles after the first request, in order, and each load returns the most recent prior store.
